// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
//   Shares a single fpu between NUM_REQ command ports. A round-robin arbiter
//   picks one pending requester, the arbiter latches that requester's opcode
//   and operands, holds fpu_start until the fpu reports cmd_end, and returns
//   the result tagged with the requester id. A watchdog turns a command that
//   never completes into an error response carrying a quiet NaN.
//
// Package pa_fpu
//   e_fpu_op : fpu opcode type shared with the fpu and the requesters.
//
// Ports
//   clk, arst_n            clock, asynchronous active-low reset
//   req_valid/op/a/b       per-requester command; held until req_ready[i]
//   req_ready              one-hot single-cycle accept pulse
//   resp_valid/id/data/err single-cycle response; id/data hold until the next one
//   fpu_start/op/a/b       command towards the fpu
//   fpu_result/cmd_end/busy status from the fpu
//   arb_busy               high whenever a command is in flight or draining
// -----------------------------------------------------------------------------
package pa_fpu;
    typedef enum logic [2:0] {
        FPU_ADD,
        FPU_SUB,
        FPU_MUL,
        FPU_DIV,
        FPU_SQRT,
        FPU_LOG2,
        FPU_EXP2,
        FPU_ABS
    } e_fpu_op;
endpackage

module fpu_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  pa_fpu::e_fpu_op       req_op [NUM_REQ],
    input  logic [31:0]           req_a  [NUM_REQ],
    input  logic [31:0]           req_b  [NUM_REQ],
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  fpu_start,
    output pa_fpu::e_fpu_op       fpu_op,
    output logic [31:0]           fpu_a,
    output logic [31:0]           fpu_b,
    input  logic [31:0]           fpu_result,
    input  logic                  fpu_cmd_end,
    input  logic                  fpu_busy,
    output logic                  arb_busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [31:0]      QNAN      = 32'h7fc0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    pa_fpu::e_fpu_op      op_q, op_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      rid_q, rid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;

    // Candidate k is the requester k positions above the round-robin pointer,
    // so the lowest valid offset is the round-robin winner.
    logic [ID_W-1:0]      cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_vld;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_en;
    logic                 timeout_hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [ID_W:0] sum;
        assign sum          = {1'b0, rr_ptr_q} + (ID_W + 1)'(gi);
        assign cand_idx[gi] = (sum >= NUM_REQ_W) ? ID_W'(sum - NUM_REQ_W) : sum[ID_W-1:0];
        assign cand_vld[gi] = req_valid[cand_idx[gi]];
    end

    always_comb begin
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                grant_idx = cand_idx[k];
            end
        end
    end

    // A grant is only possible from IDLE with the fpu free.
    assign grant_en = (state_q == S_IDLE) && !fpu_busy && (|cand_vld);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    state_d  = S_ISSUE;
                    id_d     = grant_idx;
                    op_d     = req_op[grant_idx];
                    a_d      = req_a[grant_idx];
                    b_d      = req_b[grant_idx];
                    cnt_d    = '0;
                    rr_ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
                end
            end
            S_ISSUE: begin
                // cmd_end wins over the watchdog in the final cycle.
                if (fpu_cmd_end) begin
                    state_d = S_DONE;
                    rid_d   = id_q;
                    rdata_d = fpu_result;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    rid_d   = id_q;
                    rdata_d = QNAN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Let the fpu settle so the next start is seen as a fresh command.
                if (!fpu_busy && !fpu_cmd_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= pa_fpu::FPU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            rid_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign fpu_start  = (state_q == S_ISSUE);
    assign fpu_op     = op_q;
    assign fpu_a      = a_q;
    assign fpu_b      = b_q;
    assign resp_valid = (state_q == S_DONE);
    assign resp_id    = rid_q;
    assign resp_data  = rdata_q;
    assign resp_err   = resp_valid && err_q;
    assign arb_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
`timescale 1ns/1ps
module tb_fpu_arbiter;
    import pa_fpu::*;

    localparam int N    = 4;
    localparam int TMO  = 16;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [N-1:0]    req_valid;
    e_fpu_op         req_op [N];
    logic [31:0]     req_a  [N];
    logic [31:0]     req_b  [N];
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic [ID_W-1:0] resp_id;
    logic [31:0]     resp_data;
    logic            resp_err;
    logic            fpu_start;
    e_fpu_op         fpu_op;
    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    logic [31:0]     fpu_result;
    logic            fpu_cmd_end;
    logic            fpu_busy;
    logic            arb_busy;
    logic            mdl_busy;
    logic            force_busy;

    assign fpu_busy = mdl_busy | force_busy;

    fpu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_result(fpu_result), .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // fpu behaviour knobs: cycles from first start cycle to cmd_end, or never.
    int lat  = 3;
    bit hang = 1'b0;

    // Reference model state.
    int          mdl_ptr = 0;
    bit          pend = 1'b0;
    int          cyc = 0;
    int          g_cyc = 0;
    int          g_explat = 0;
    logic [31:0] exp_data;
    logic [ID_W-1:0] exp_id;
    bit          exp_err;
    e_fpu_op     g_op;
    logic [31:0] g_a, g_b;
    logic [31:0] last_data = '0;
    logic [ID_W-1:0] last_id = '0;
    int          last_lat = 0;
    int          n_resp = 0;
    int          grant_log[$];
    logic [31:0] rlog[$];
    bit          elog[$];
    bit          granted [N];
    int          left [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in fpu arithmetic: exact results for the directed vectors, a
    // deterministic scramble elsewhere (the arbiter only forwards it).
    function automatic logic [31:0] fpu_fn(input e_fpu_op op, input logic [31:0] a, input logic [31:0] b);
        if (op == FPU_LOG2 && a == 32'h3f000000) return 32'hbf800000;
        if (op == FPU_ADD && a == 32'h41800000 && b == 32'h42000000) return 32'h42400000;
        if (op == FPU_MUL && a == 32'h3e800000 && b == 32'h3f000000) return 32'h3e000000;
        return a ^ {b[15:0], b[31:16]} ^ 32'(op);
    endfunction

    function automatic int exp_winner();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
        end
        return -1;
    endfunction

    // ---------------- fpu model ----------------
    bit          m_active = 1'b0;
    int          m_rem = 0;
    e_fpu_op     m_op;
    logic [31:0] m_a, m_b;

    initial begin
        mdl_busy    = 1'b0;
        fpu_cmd_end = 1'b0;
        fpu_result  = '0;
        forever begin
            @(posedge clk); #2;
            if (!arst_n) begin
                m_active = 1'b0; mdl_busy = 1'b0; fpu_cmd_end = 1'b0;
            end else if (m_active) begin
                if (fpu_cmd_end) begin
                    fpu_cmd_end = 1'b0; mdl_busy = 1'b0; m_active = 1'b0;
                    chk("start_low_after_end", 32'(fpu_start), 32'd0);
                end else if (hang && !fpu_start) begin
                    mdl_busy = 1'b0; m_active = 1'b0;
                end else begin
                    chk("start_held", 32'(fpu_start), 32'd1);
                    chk("fpu_op_stable", 32'(fpu_op), 32'(m_op));
                    chk("fpu_a_stable", fpu_a, m_a);
                    chk("fpu_b_stable", fpu_b, m_b);
                    if (!hang) begin
                        m_rem--;
                        if (m_rem == 0) begin
                            fpu_cmd_end = 1'b1;
                            fpu_result  = fpu_fn(m_op, m_a, m_b);
                        end
                    end
                end
            end else if (fpu_start) begin
                m_active = 1'b1; mdl_busy = 1'b1; m_rem = lat;
                m_op = fpu_op; m_a = fpu_a; m_b = fpu_b;
                chk("issued_op", 32'(fpu_op), 32'(g_op));
                chk("issued_a", fpu_a, g_a);
                chk("issued_b", fpu_b, g_b);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        int w;
        if (!arst_n) begin
            mdl_ptr = 0; pend = 1'b0; last_id = '0; last_data = '0;
            for (int i = 0; i < N; i++) granted[i] = 1'b0;
        end else begin
            cyc++;
            if (req_ready != '0) begin
                w = exp_winner();
                if (w < 0) begin
                    chk("grant_without_valid", 32'(req_ready), 32'd0);
                end else begin
                    chk("grant_onehot", 32'(req_ready), 32'd1 << w);
                    chk("grant_not_busy", 32'(fpu_busy), 32'd0);
                    chk("grant_after_resp", 32'(pend), 32'd0);
                    chk("ready_resp_excl", 32'(resp_valid), 32'd0);
                    g_op = req_op[w]; g_a = req_a[w]; g_b = req_b[w];
                    exp_id   = ID_W'(w);
                    exp_err  = hang;
                    exp_data = hang ? 32'h7fc00000 : fpu_fn(req_op[w], req_a[w], req_b[w]);
                    g_explat = hang ? TMO + 1 : lat + 2;
                    g_cyc    = cyc;
                    grant_log.push_back(w);
                    mdl_ptr    = (w + 1) % N;
                    pend       = 1'b1;
                    granted[w] = 1'b1;
                end
            end
            if (resp_valid) begin
                chk("resp_has_grant", 32'(pend), 32'd1);
                chk("resp_id", 32'(resp_id), 32'(exp_id));
                chk("resp_data", resp_data, exp_data);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                chk("resp_latency", 32'(cyc - g_cyc), 32'(g_explat));
                last_lat = cyc - g_cyc;
                pend = 1'b0; last_id = resp_id; last_data = resp_data;
                rlog.push_back(resp_data); elog.push_back(resp_err);
                n_resp++;
            end else begin
                chk("resp_id_hold", 32'(resp_id), 32'(last_id));
                chk("resp_data_hold", resp_data, last_data);
                chk("resp_err_idle", 32'(resp_err), 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input e_fpu_op op, input logic [31:0] a,
                           input logic [31:0] b, input int n);
        req_op[i] = op; req_a[i] = a; req_b[i] = b; left[i] = n; req_valid[i] = 1'b1;
    endtask

    task automatic load_rand(input int i);
        req_op[i] = e_fpu_op'(3'($urandom_range(0, 7)));
        req_a[i]  = $urandom;
        req_b[i]  = $urandom;
        req_valid[i] = 1'b1;
    endtask

    // Keeps every requester's valid up until it has been served `left` times,
    // then waits for the outstanding response.
    task automatic run(input int budget, input bit may_drop);
        int t; bit done; int rem;
        t = 0; done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            rem = 0;
            for (int i = 0; i < N; i++) begin
                if (granted[i]) begin
                    granted[i] = 1'b0;
                    left[i]--;
                    if (left[i] > 0) load_rand(i); else req_valid[i] = 1'b0;
                end else if (may_drop && req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0; left[i] = 0;
                end
                rem += left[i];
            end
            t++;
            if (rem == 0 && !pend) done = 1'b1;
            else if (t > budget) begin
                chk("run_timeout", 32'(t), 32'(budget));
                done = 1'b1;
            end
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        chk({tag, "_resp_data"}, resp_data, 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_fpu_start"}, 32'(fpu_start), 32'd0);
        chk({tag, "_fpu_op"}, 32'(fpu_op), 32'(FPU_ADD));
        chk({tag, "_fpu_a"}, fpu_a, 32'd0);
        chk({tag, "_fpu_b"}, fpu_b, 32'd0);
        chk({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int mark; int k; int nr;
        arst_n = 1'b0; req_valid = '0; force_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_op[i] = FPU_ADD; req_a[i] = '0; req_b[i] = '0; left[i] = 0; granted[i] = 1'b0;
        end
        #3;
        chk_reset_outs("por");
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        // 1: single log2 request from r0
        lat = 4;
        set_req(0, FPU_LOG2, 32'h3f000000, 32'h0, 1);
        run(200, 1'b0);
        chk("t1_n_resp", 32'(n_resp), 32'd1);
        chk("t1_resp_id", 32'(last_id), 32'd0);
        chk("t1_resp_data", last_data, 32'hbf800000);

        // 2: contention r1 add vs r3 mul
        lat = 2; mark = grant_log.size(); nr = rlog.size();
        set_req(1, FPU_ADD, 32'h41800000, 32'h42000000, 1);
        set_req(3, FPU_MUL, 32'h3e800000, 32'h3f000000, 1);
        run(200, 1'b0);
        chk("t2_first", 32'(grant_log[mark]), 32'd1);
        chk("t2_second", 32'(grant_log[mark+1]), 32'd3);
        chk("t2_data1", rlog[nr], 32'h42400000);
        chk("t2_data3", rlog[nr+1], 32'h3e000000);

        // 3: fairness, all four held for 8 commands
        lat = 3; mark = grant_log.size();
        for (int i = 0; i < N; i++) begin load_rand(i); left[i] = 2; end
        run(400, 1'b0);
        chk("t3_count", 32'(grant_log.size() - mark), 32'd8);
        for (int j = 0; j < 8; j++) chk("t3_order", 32'(grant_log[mark+j]), 32'(j % 4));

        // 4: watchdog timeout
        hang = 1'b1;
        load_rand(1); left[1] = 1;
        run(200, 1'b0);
        chk("t4_err", 32'(elog[elog.size()-1]), 32'd1);
        chk("t4_data", last_data, 32'h7fc00000);
        chk("t4_latency", 32'(last_lat), 32'(TMO + 1));
        hang = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("t4_idle", 32'(arb_busy), 32'd0);

        // 4b: cmd_end in the final watchdog cycle is a normal completion
        lat = TMO - 1;
        set_req(2, FPU_LOG2, 32'h3f000000, 32'h0, 1);
        run(200, 1'b0);
        chk("t4b_err", 32'(elog[elog.size()-1]), 32'd0);
        chk("t4b_data", last_data, 32'hbf800000);
        chk("t4b_latency", 32'(last_lat), 32'(TMO + 1));

        // random traffic with occasional withdrawal before grant
        for (int r = 0; r < 30; r++) begin
            lat = $urandom_range(1, 6);
            k = $urandom_range(1, 15);
            for (int i = 0; i < N; i++) begin
                if (k[i]) begin load_rand(i); left[i] = $urandom_range(1, 2); end
            end
            run(400, 1'b1);
        end

        // 5: reset in the third busy cycle of a command
        repeat (3) @(posedge clk); #1;
        lat = 10;
        set_req(2, FPU_SQRT, $urandom, $urandom, 1);
        k = 0;
        for (int t = 0; t < 60 && k < 3; t++) begin
            @(posedge clk); #3;
            if (fpu_busy) k++;
        end
        chk("t5_busy_seen", 32'(k), 32'd3);
        nr = n_resp;
        arst_n = 1'b0;
        #1;
        chk_reset_outs("mid_reset");
        req_valid = '0;
        for (int i = 0; i < N; i++) left[i] = 0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("t5_no_resp", 32'(n_resp), 32'(nr));
        lat = 3; mark = grant_log.size();
        load_rand(2); left[2] = 1;
        load_rand(3); left[3] = 1;
        run(200, 1'b0);
        chk("t5_first", 32'(grant_log[mark]), 32'd2);
        chk("t5_second", 32'(grant_log[mark+1]), 32'd3);

        // 6: no acceptance while the fpu reports busy
        repeat (3) @(posedge clk); #1;
        force_busy = 1'b1; mark = grant_log.size();
        load_rand(0); left[0] = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_no_grant", 32'(grant_log.size() - mark), 32'd0);
        @(posedge clk); #1 force_busy = 1'b0;
        @(negedge clk);
        chk("t6_grant_now", 32'(req_ready), 32'd1);
        run(200, 1'b0);
        chk("t6_served", 32'(grant_log.size() - mark), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
